// File: rtl/audio_sample_scheduler.sv
// Paces buffered audio samples into the Serializer, one word per sample tick.
// Define SCHED_HOLD_LAST_EN to repeat the last popped sample on underrun instead of silence.
module audio_sample_scheduler #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int SAMPLE_DIV = 2268
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          run,
   input  logic                          wr_valid,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ready,
   output logic                          ser_enable,
   output logic [DATA_W-1:0]             ser_data,
   input  logic                          ser_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic [7:0]                    underrun_cnt,
   output logic                          overrun,
   input  logic                          clr_status
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(SAMPLE_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

   state_t               state, state_next;
   logic [CNT_W-1:0]     tick_cnt;
   logic                 tick;
   logic [DATA_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [LVL_W-1:0]     count;
   logic                 full, empty, push, pop, idle_tick;
   logic [DATA_W-1:0]    underrun_val;

   assign tick      = run && (tick_cnt == CNT_W'(SAMPLE_DIV - 1));
   assign full      = (count == LVL_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign idle_tick = (state == IDLE) && tick;
   assign pop       = idle_tick && !empty;
   // A pop in the same cycle frees a slot, so a full FIFO can still take a write.
   assign wr_ready  = !full || pop;
   assign push      = wr_valid && wr_ready;

   assign fifo_level = count;
   assign ser_enable = (state == SHIFT);
   assign busy       = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (!run || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

`ifdef SCHED_HOLD_LAST_EN
   logic [DATA_W-1:0] last_sample;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_sample <= '0;
      end else if (pop) begin
         last_sample <= mem[rd_ptr];
      end
   end

   assign underrun_val = last_sample;
`else
   assign underrun_val = '0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // GAP holds enable low for one cycle so every word starts on a fresh rising enable.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tick) state_next = SHIFT;
         SHIFT:   if (ser_done) state_next = GAP;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ser_data <= '0;
      end else if (idle_tick) begin
         ser_data <= empty ? underrun_val : mem[rd_ptr];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         underrun_cnt <= '0;
         overrun      <= 1'b0;
      end else if (clr_status) begin
         underrun_cnt <= '0;
         overrun      <= 1'b0;
      end else begin
         if (idle_tick && empty && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 1'b1;
         if (tick && state != IDLE) overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed self-checking bench for audio_sample_scheduler with a short sample period.
module tb_audio_sample_scheduler;

   localparam int DATA_W     = 16;
   localparam int FIFO_DEPTH = 8;
   localparam int SAMPLE_DIV = 8;

`ifdef SCHED_HOLD_LAST_EN
   localparam logic [15:0] UNDERRUN_VAL = 16'hABCD;
`else
   localparam logic [15:0] UNDERRUN_VAL = 16'h0000;
`endif

   logic              clock;
   logic              reset_n;
   logic              run;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              ser_enable;
   logic [DATA_W-1:0] ser_data;
   logic              ser_done;
   logic [3:0]        fifo_level;
   logic              busy;
   logic [7:0]        underrun_cnt;
   logic              overrun;
   logic              clr_status;

   int checkCount = 0;
   int errorCount = 0;

   audio_sample_scheduler #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH),
      .SAMPLE_DIV (SAMPLE_DIV)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .run          (run),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .ser_enable   (ser_enable),
      .ser_data     (ser_data),
      .ser_done     (ser_done),
      .fifo_level   (fifo_level),
      .busy         (busy),
      .underrun_cnt (underrun_cnt),
      .overrun      (overrun),
      .clr_status   (clr_status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [DATA_W-1:0] sample);
      wr_valid = 1'b1;
      wr_data  = sample;
      step();
      wr_valid = 1'b0;
   endtask

   task automatic waitForEnable(input string tag);
      int i;
      i = 0;
      while (!ser_enable && i < 40) begin
         step();
         i++;
      end
      checkOutput({tag, "_en"}, 32'(ser_enable), 32'd1);
   endtask

   task automatic pulseDone();
      ser_done = 1'b1;
      step();
      ser_done = 1'b0;
      step();
   endtask

   initial begin
      reset_n    = 1'b0;
      run        = 1'b0;
      wr_valid   = 1'b0;
      wr_data    = '0;
      ser_done   = 1'b0;
      clr_status = 1'b0;
      #12;
      checkOutput("rst_enable",   32'(ser_enable),   32'd0);
      checkOutput("rst_data",     32'(ser_data),     32'd0);
      checkOutput("rst_wr_ready", 32'(wr_ready),     32'd1);
      checkOutput("rst_level",    32'(fifo_level),   32'd0);
      checkOutput("rst_busy",     32'(busy),         32'd0);
      checkOutput("rst_underrun", 32'(underrun_cnt), 32'd0);
      checkOutput("rst_overrun",  32'(overrun),      32'd0);
      reset_n = 1'b1;
      step();

      $display("[TB] basic pacing");
      run = 1'b1;
      wr_valid = 1'b1;
      wr_data = 16'h8001;
      step();
      wr_data = 16'h1234;
      step();
      wr_valid = 1'b0;
      checkOutput("t1_level2", 32'(fifo_level), 32'd2);
      step(5);
      checkOutput("t1_pre_tick_en", 32'(ser_enable), 32'd0);
      step();
      checkOutput("t1_first_en",   32'(ser_enable), 32'd1);
      checkOutput("t1_first_data", 32'(ser_data),   32'h8001);
      checkOutput("t1_level1",     32'(fifo_level), 32'd1);
      checkOutput("t1_busy",       32'(busy),       32'd1);
      step(4);
      ser_done = 1'b1;
      step();
      ser_done = 1'b0;
      checkOutput("t1_gap_en",   32'(ser_enable), 32'd0);
      checkOutput("t1_gap_busy", 32'(busy),       32'd1);
      step();
      checkOutput("t1_idle_busy", 32'(busy), 32'd0);
      step();
      checkOutput("t1_tick2_en", 32'(ser_enable), 32'd0);
      step();
      checkOutput("t1_second_en",   32'(ser_enable), 32'd1);
      checkOutput("t1_second_data", 32'(ser_data),   32'h1234);
      checkOutput("t1_level0",      32'(fifo_level), 32'd0);
      run = 1'b0;
      pulseDone();
      checkOutput("t1_end_busy", 32'(busy), 32'd0);

      $display("[TB] fill, overflow and drain");
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("t2_ready_%0d", i), 32'(wr_ready), (i < 8) ? 32'd1 : 32'd0);
         applyStimulus(16'h1000 + 16'(i));
      end
      checkOutput("t2_full_level", 32'(fifo_level), 32'd8);
      checkOutput("t2_full_ready", 32'(wr_ready),   32'd0);
      run = 1'b1;
      step(7);
      checkOutput("t2_pop_ready", 32'(wr_ready), 32'd1);
      wr_valid = 1'b1;
      wr_data  = 16'hBEEF;
      step();
      wr_valid = 1'b0;
      checkOutput("t2_pushpop_level", 32'(fifo_level), 32'd8);
      for (int i = 0; i < 9; i++) begin
         waitForEnable($sformatf("t2_word%0d", i));
         checkOutput($sformatf("t2_data%0d", i), 32'(ser_data),
                     (i < 8) ? (32'h1000 + 32'(i)) : 32'hBEEF);
         pulseDone();
      end
      run = 1'b0;
      checkOutput("t2_drained", 32'(fifo_level), 32'd0);
      checkOutput("t2_no_underrun", 32'(underrun_cnt), 32'd0);

      $display("[TB] underrun");
      applyStimulus(16'hABCD);
      run = 1'b1;
      waitForEnable("t3_abcd");
      checkOutput("t3_abcd_data", 32'(ser_data), 32'hABCD);
      pulseDone();
      for (int i = 0; i < 3; i++) begin
         waitForEnable($sformatf("t3_under%0d", i));
         checkOutput($sformatf("t3_under_data%0d", i), 32'(ser_data), 32'(UNDERRUN_VAL));
         pulseDone();
      end
      run = 1'b0;
      checkOutput("t3_underrun_cnt", 32'(underrun_cnt), 32'd3);
      checkOutput("t3_overrun",      32'(overrun),      32'd0);

      $display("[TB] overrun and status clear");
      applyStimulus(16'h5555);
      applyStimulus(16'h6666);
      checkOutput("t4_level2", 32'(fifo_level), 32'd2);
      run = 1'b1;
      waitForEnable("t4_5555");
      checkOutput("t4_data",   32'(ser_data),   32'h5555);
      checkOutput("t4_level1", 32'(fifo_level), 32'd1);
      step(9);
      checkOutput("t4_overrun",     32'(overrun),      32'd1);
      checkOutput("t4_no_pop",      32'(fifo_level),   32'd1);
      checkOutput("t4_still_en",    32'(ser_enable),   32'd1);
      checkOutput("t4_stable_data", 32'(ser_data),     32'h5555);
      checkOutput("t4_underrun",    32'(underrun_cnt), 32'd3);
      run = 1'b0;
      pulseDone();
      checkOutput("t4_idle", 32'(busy), 32'd0);
      ser_done = 1'b1;
      step();
      ser_done = 1'b0;
      step();
      checkOutput("t4_done_idle_busy", 32'(busy),       32'd0);
      checkOutput("t4_done_idle_en",   32'(ser_enable), 32'd0);
      clr_status = 1'b1;
      step();
      clr_status = 1'b0;
      checkOutput("t4_clr_overrun",  32'(overrun),      32'd0);
      checkOutput("t4_clr_underrun", 32'(underrun_cnt), 32'd0);

      $display("[TB] reset mid-word");
      run = 1'b1;
      waitForEnable("t5_6666");
      checkOutput("t5_data", 32'(ser_data), 32'h6666);
      applyStimulus(16'h7777);
      checkOutput("t5_level1", 32'(fifo_level), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("t5_rst_en",    32'(ser_enable), 32'd0);
      checkOutput("t5_rst_level", 32'(fifo_level), 32'd0);
      checkOutput("t5_rst_busy",  32'(busy),       32'd0);
      checkOutput("t5_rst_data",  32'(ser_data),   32'd0);
      run = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      applyStimulus(16'h4242);
      run = 1'b1;
      step(7);
      checkOutput("t5_pre_tick_en", 32'(ser_enable), 32'd0);
      step();
      checkOutput("t5_post_en",   32'(ser_enable), 32'd1);
      checkOutput("t5_post_data", 32'(ser_data),   32'h4242);
      run = 1'b0;
      pulseDone();

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
